debouncer_multi: RTL

// - Parametrised N-channel debouncer for push-buttons and switches. Next generation of the single-channel delayed debouncer.
// - Per channel: input synchroniser, 4-state FSM and private stable-time counter, so the block needs no external timer.
// - Two modes: DELAYED, where the output follows only after the input has been stable, and EARLY, where the output follows the first edge and then locks out.
// - Gives one-cycle rise/fall pulses so downstream FSMs need no edge detector.

---
 rtl/debouncer_multi.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/debouncer_multi.sv
// debouncer_multi: N independent debounce channels. Each channel has its own
// input synchroniser, a four-state FSM and a private stable-time counter.
// MODE 0 (DELAYED) changes the output only after the input has been stable.
// MODE 1 (EARLY) follows the first edge at once and then ignores the input
// until the lockout time has run out.
// All outputs are registered. rise/fall are single-cycle pulses that line up
// with the change of debounced.
module debouncer_multi #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 2_000_000,
  parameter int SYNC_STAGES   = 2,
  parameter int MODE          = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] busy
);

  // Counter wide enough to reach STABLE_CYCLES-1. The guard keeps the width
  // legal when parameters are bad, so that the $error below gets reported.
  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam bit EARLY = (MODE == 1);

  // PEND_H/PEND_L stand for WAIT_* in DELAYED mode and HOLD_* in EARLY mode.
  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_PEND_H = 2'd1,
    ST_HIGH   = 2'd2,
    ST_PEND_L = 2'd3
  } state_t;

  if (CHANNELS < 1) begin : g_err_channels
    $error("debouncer_multi: CHANNELS must be >= 1");
  end
  if (STABLE_CYCLES < 2) begin : g_err_stable
    $error("debouncer_multi: STABLE_CYCLES must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_err_sync
    $error("debouncer_multi: SYNC_STAGES must be >= 2");
  end
  if ((MODE != 0) && (MODE != 1)) begin : g_err_mode
    $error("debouncer_multi: MODE must be 0 (DELAYED) or 1 (EARLY)");
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;
    logic                   done;
    state_t                 state_reg;
    logic [CW-1:0]          cnt_reg;
    logic                   deb_reg;
    logic                   rise_reg;
    logic                   fall_reg;
    logic                   busy_reg;

    // Shift the raw pin through the synchroniser chain.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_reg <= '0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], noisy[gi]};
      end
    end

    assign s    = sync_reg[SYNC_STAGES-1];
    assign done = (cnt_reg == CNT_LAST);

    // Channel FSM. It updates the state, the counter and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_reg <= ST_LOW;
        cnt_reg   <= '0;
        deb_reg   <= 1'b0;
        rise_reg  <= 1'b0;
        fall_reg  <= 1'b0;
        busy_reg  <= 1'b0;
      end else begin
        rise_reg <= 1'b0;
        fall_reg <= 1'b0;
        case (state_reg)
          ST_LOW: begin
            if (s) begin
              state_reg <= ST_PEND_H;
              cnt_reg   <= '0;
              busy_reg  <= 1'b1;
              if (EARLY) begin
                deb_reg  <= 1'b1;
                rise_reg <= 1'b1;
              end
            end
          end
          ST_PEND_H: begin
            if (!EARLY && !s) begin
              // The input went low again before it was stable: abort quietly.
              state_reg <= ST_LOW;
              cnt_reg   <= '0;
              busy_reg  <= 1'b0;
            end else if (done) begin
              state_reg <= ST_HIGH;
              cnt_reg   <= '0;
              busy_reg  <= 1'b0;
              if (!EARLY) begin
                deb_reg  <= 1'b1;
                rise_reg <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          ST_HIGH: begin
            if (!s) begin
              state_reg <= ST_PEND_L;
              cnt_reg   <= '0;
              busy_reg  <= 1'b1;
              if (EARLY) begin
                deb_reg  <= 1'b0;
                fall_reg <= 1'b1;
              end
            end
          end
          ST_PEND_L: begin
            if (!EARLY && s) begin
              state_reg <= ST_HIGH;
              cnt_reg   <= '0;
              busy_reg  <= 1'b0;
            end else if (done) begin
              state_reg <= ST_LOW;
              cnt_reg   <= '0;
              busy_reg  <= 1'b0;
              if (!EARLY) begin
                deb_reg  <= 1'b0;
                fall_reg <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          default: begin
            state_reg <= ST_LOW;
            cnt_reg   <= '0;
            deb_reg   <= 1'b0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end

    assign debounced[gi] = deb_reg;
    assign rise[gi]      = rise_reg;
    assign fall[gi]      = fall_reg;
    assign busy[gi]      = busy_reg;
  end

endmodule
